// File: rtl/serdes_pkg.sv
// Shared SerDes PHY constants: symbol width and the two K28.5 comma forms.
package serdes_pkg;

   localparam int unsigned SYMBOL_W = 10;
   localparam int unsigned CNT_W    = 4;

   localparam logic [SYMBOL_W-1:0] K285_RDN = 10'b0011111010;
   localparam logic [SYMBOL_W-1:0] K285_RDP = 10'b1100000101;

endpackage

// File: rtl/tx_serializer.sv
// TX parallel-to-serial converter: 10-bit code groups out LSB first, with
// a one-word holding register and K28.5 comma fill whenever no data is ready.
module tx_serializer
   import serdes_pkg::*;
#(
   parameter int unsigned       DATA_W   = SYMBOL_W,
   parameter logic [DATA_W-1:0] IDLE_NEG = K285_RDN,
   parameter logic [DATA_W-1:0] IDLE_POS = K285_RDP
) (
   input  logic              Bit_Clk,
   input  logic              Rst_n,
   input  logic              TxPolarity,
   input  logic [DATA_W-1:0] Data_in,
   input  logic              Data_Valid,
   output logic              Data_Ready,
   output logic              Ser_out,
   output logic              Word_Start
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              pol_q, pol_d;
   logic              idle_rd_q, idle_rd_d;
   logic              load;
   logic              accept;

   assign load       = (cnt_q == LAST_BIT);
   assign Data_Ready = ~hold_full_q | load;
   assign accept     = Data_Valid & Data_Ready;
   assign Ser_out    = shift_q[0] ^ pol_q;
   assign Word_Start = (cnt_q == '0);

   // Next-state: load a new word on the last bit, otherwise shift and buffer.
   always_comb begin
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      pol_d       = pol_q;
      idle_rd_d   = idle_rd_q;

      if (load) begin
         cnt_d = '0;
         pol_d = TxPolarity;
         if (hold_full_q) begin
            shift_d = hold_q;
         end else if (accept) begin
            shift_d = Data_in;
         end else begin
            shift_d   = idle_rd_q ? IDLE_POS : IDLE_NEG;
            idle_rd_d = ~idle_rd_q;
         end
         if (accept && hold_full_q) begin
            hold_d = Data_in;
         end
         hold_full_d = hold_full_q & accept;
      end else begin
         cnt_d   = cnt_q + CNT_W'(1);
         shift_d = shift_q >> 1;
         if (accept) begin
            hold_d      = Data_in;
            hold_full_d = 1'b1;
         end
      end
   end

   // Reset parks the counter on the last bit so the first live edge loads.
   always_ff @(posedge Bit_Clk) begin
      if (!Rst_n) begin
         cnt_q       <= LAST_BIT;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         pol_q       <= 1'b0;
         idle_rd_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         pol_q       <= pol_d;
         idle_rd_q   <= idle_rd_d;
      end
   end

endmodule

// File: tb/tb_tx_serializer.sv
// Self-checking bench for tx_serializer: table of word-level scenarios plus
// hand-written polarity, mid-word reset and rejected-pulse sequences.
module tb_tx_serializer;

   localparam logic [9:0] NEG = 10'h0FA;
   localparam logic [9:0] POS = 10'h305;

   bit         Bit_Clk = 1'b0;
   logic       Rst_n;
   logic       TxPolarity;
   logic [9:0] Data_in;
   logic       Data_Valid;
   logic       Data_Ready;
   logic       Ser_out;
   logic       Word_Start;

   tx_serializer dut (
      .Bit_Clk    (Bit_Clk),
      .Rst_n      (Rst_n),
      .TxPolarity (TxPolarity),
      .Data_in    (Data_in),
      .Data_Valid (Data_Valid),
      .Data_Ready (Data_Ready),
      .Ser_out    (Ser_out),
      .Word_Start (Word_Start)
   );

   initial forever #5 Bit_Clk = ~Bit_Clk;

   int checks = 0;
   int errors = 0;

   // Line monitor: reassembles words on Word_Start, flags partial words and gaps.
   bit         rst_applied = 1'b0;
   logic [9:0] rx_words [256];
   int         rx_cnt      = 0;
   int         partial_err = 0;
   int         gap_err     = 0;
   int         rst_bad     = 0;
   int         base        = 0;

   always @(posedge Bit_Clk) rst_applied <= !Rst_n;

   initial begin
      int         bit_idx;
      logic [9:0] cur;
      bit_idx = 0;
      cur     = '0;
      forever begin
         @(negedge Bit_Clk);
         if (rst_applied) begin
            bit_idx = 0;
            if (Ser_out !== 1'b0 || Word_Start !== 1'b0 || Data_Ready !== 1'b1) rst_bad++;
         end else if (Word_Start === 1'b1) begin
            if (bit_idx != 0 && bit_idx != 10) partial_err++;
            cur     = '0;
            cur[0]  = Ser_out;
            bit_idx = 1;
         end else if (bit_idx >= 1 && bit_idx <= 9) begin
            cur[bit_idx[3:0]] = Ser_out;
            bit_idx++;
            if (bit_idx == 10 && rx_cnt < 256) begin
               rx_words[rx_cnt] = cur;
               rx_cnt++;
            end
         end else if (bit_idx == 10) begin
            gap_err++;
            bit_idx = 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Bit_Clk);
      #1;
   endtask

   task automatic reset_dut();
      Rst_n      = 1'b0;
      Data_Valid = 1'b0;
      TxPolarity = 1'b0;
      tick();
      tick();
      check("rst_ser_out",    32'(Ser_out),    32'd0);
      check("rst_word_start", 32'(Word_Start), 32'd0);
      check("rst_data_ready", 32'(Data_Ready), 32'd1);
      base  = rx_cnt;
      Rst_n = 1'b1;
   endtask

   // Present a word and hold it until accepted; reports cycles spent waiting.
   task automatic send(input logic [9:0] d, output int waits);
      Data_in    = d;
      Data_Valid = 1'b1;
      waits      = 0;
      while (Data_Ready !== 1'b1 && waits < 40) begin
         tick();
         waits++;
      end
      tick();
      Data_Valid = 1'b0;
   endtask

   task automatic wait_words(input int n);
      int g;
      g = 0;
      while ((rx_cnt - base) < n && g < 200) begin
         tick();
         g++;
      end
      check("word_count_reached", 32'((rx_cnt - base) >= n), 32'd1);
   endtask

   task automatic expect_word(input string name, input int idx, input logic [9:0] exp);
      check(name, 32'(rx_words[base + idx]), 32'(exp));
   endtask

   typedef struct packed {
      logic [2:0]       n_in;
      logic [3:0][9:0]  din;
      logic [3:0][7:0]  gap;
      logic [3:0][7:0]  wt;
      logic [2:0]       n_out;
      logic [5:0][9:0]  dout;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int w;
      Rst_n      = 1'b0;
      TxPolarity = 1'b0;
      Data_in    = '0;
      Data_Valid = 1'b0;

      for (int v = 0; v < 5; v++) vecs[v] = '0;
      // Idle only: comma alternation from RD-.
      vecs[0].n_out = 3'd4;
      vecs[0].dout[0] = NEG; vecs[0].dout[1] = POS;
      vecs[0].dout[2] = NEG; vecs[0].dout[3] = POS;
      // Single bypass word on the second load cycle.
      vecs[1].n_in = 3'd1;
      vecs[1].din[0] = 10'h2AA; vecs[1].gap[0] = 8'd10; vecs[1].wt[0] = 8'd0;
      vecs[1].n_out = 3'd4;
      vecs[1].dout[0] = NEG; vecs[1].dout[1] = 10'h2AA;
      vecs[1].dout[2] = POS; vecs[1].dout[3] = NEG;
      // Back-to-back stream; hold fills, then ready only on load cycles.
      vecs[2].n_in = 3'd4;
      vecs[2].din[0] = 10'h155; vecs[2].wt[0] = 8'd0;
      vecs[2].din[1] = 10'h3F0; vecs[2].wt[1] = 8'd0;
      vecs[2].din[2] = 10'h00F; vecs[2].wt[2] = 8'd8;
      vecs[2].din[3] = 10'h2AA; vecs[2].wt[3] = 8'd9;
      vecs[2].n_out = 3'd6;
      vecs[2].dout[0] = 10'h155; vecs[2].dout[1] = 10'h3F0; vecs[2].dout[2] = 10'h00F;
      vecs[2].dout[3] = 10'h2AA; vecs[2].dout[4] = NEG;     vecs[2].dout[5] = POS;
      // Mid-word accept into empty hold starts at next Word_Start.
      vecs[3].n_in = 3'd1;
      vecs[3].din[0] = 10'h3F0; vecs[3].gap[0] = 8'd3; vecs[3].wt[0] = 8'd0;
      vecs[3].n_out = 3'd3;
      vecs[3].dout[0] = NEG; vecs[3].dout[1] = 10'h3F0; vecs[3].dout[2] = POS;
      // Hold filled on cnt=8, second word accepted on the load cycle itself.
      vecs[4].n_in = 3'd2;
      vecs[4].din[0] = 10'h00F; vecs[4].gap[0] = 8'd9; vecs[4].wt[0] = 8'd0;
      vecs[4].din[1] = 10'h155; vecs[4].gap[1] = 8'd0; vecs[4].wt[1] = 8'd0;
      vecs[4].n_out = 3'd4;
      vecs[4].dout[0] = NEG;     vecs[4].dout[1] = 10'h00F;
      vecs[4].dout[2] = 10'h155; vecs[4].dout[3] = POS;

      for (int v = 0; v < 5; v++) begin
         reset_dut();
         for (int i = 0; i < int'(vecs[v].n_in); i++) begin
            repeat (int'(vecs[v].gap[i])) tick();
            send(vecs[v].din[i], w);
            check($sformatf("v%0d_wait%0d", v, i), 32'(w), 32'(vecs[v].wt[i]));
         end
         wait_words(int'(vecs[v].n_out));
         for (int i = 0; i < int'(vecs[v].n_out); i++)
            expect_word($sformatf("v%0d_word%0d", v, i), i, vecs[v].dout[i]);
      end

      // Polarity flips at cnt=4: current word unaffected, next word inverted.
      reset_dut();
      send(10'h155, w);
      @(negedge Bit_Clk);
      check("bypass_word_start", 32'(Word_Start), 32'd1);
      check("bypass_bit0",       32'(Ser_out),    32'd1);
      send(10'h155, w);
      repeat (3) tick();
      TxPolarity = 1'b1;
      wait_words(3);
      expect_word("pol_word0", 0, 10'h155);
      expect_word("pol_word1", 1, 10'h2AA);
      expect_word("pol_idle",  2, POS);
      TxPolarity = 1'b0;

      // One-cycle reset at cnt=6 with hold full: both words lost.
      reset_dut();
      send(10'h155, w);
      send(10'h3F0, w);
      repeat (5) tick();
      Rst_n = 1'b0;
      tick();
      check("midrst_ser_out",    32'(Ser_out),    32'd0);
      check("midrst_word_start", 32'(Word_Start), 32'd0);
      check("midrst_data_ready", 32'(Data_Ready), 32'd1);
      base  = rx_cnt;
      Rst_n = 1'b1;
      wait_words(2);
      expect_word("midrst_word0", 0, NEG);
      expect_word("midrst_word1", 1, POS);

      // Valid pulse while not ready is ignored.
      reset_dut();
      send(10'h155, w);
      send(10'h3F0, w);
      repeat (2) tick();
      check("pulse_not_ready", 32'(Data_Ready), 32'd0);
      Data_in    = 10'h00F;
      Data_Valid = 1'b1;
      tick();
      Data_Valid = 1'b0;
      wait_words(4);
      expect_word("pulse_word0", 0, 10'h155);
      expect_word("pulse_word1", 1, 10'h3F0);
      expect_word("pulse_word2", 2, NEG);
      expect_word("pulse_word3", 3, POS);

      check("partial_words",    32'(partial_err), 32'd0);
      check("word_start_gaps",  32'(gap_err),     32'd0);
      check("reset_line_state", 32'(rst_bad),     32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
